imem_loader: RTL and testbench

- Write-side companion to the instruction memory.
- Receives a byte stream from a host link (UART/debug bridge) over a valid/ready handshake and assembles little-endian 32-bit words.
- Issues word-indexed write strobes into the instruction memory.
- Holds the core in reset until a complete program image has been loaded.

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 174 +++++++++++++++++
 tb/tb_imem_loader.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus shared by imem_loader and its host.
// The slave modport is the loader side; the master modport is the host/memory side.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 6
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian program image into instruction memory and holds the core in reset until done.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    imem_loader_if.slave      bus,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERROR, S_CHK
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [1:0]        byte_idx;
    logic [23:0]       word_buf;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [WORD_W-1:0] wr_data_q;
    logic              in_ready_c;
    logic [LEN_W-1:0]  len_rx;
    logic [CNT_W-1:0]  cnt_next;
    logic              last_word;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]        chk_q;
`endif

    assign len_rx    = {bus.in_data, len_q[7:0]};
    assign cnt_next  = words_loaded + CNT_W'(1);
    assign last_word = (LEN_W'(cnt_next) == len_q);

    assign bus.in_ready = in_ready_c;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

    // Byte acceptance is a pure state decode so a stall never costs a cycle.
    always_comb begin
        in_ready_c = 1'b0;
        case (state)
            S_LEN0, S_LEN1, S_DATA: in_ready_c = 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
            S_CHK:                  in_ready_c = 1'b1;
`endif
            default:                in_ready_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            len_q        <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            core_rst_n   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state        <= S_LEN0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        core_rst_n   <= 1'b0;
                        words_loaded <= '0;
                        byte_idx     <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
                        chk_q        <= '0;
`endif
                    end
                end
                S_LEN0: begin
                    if (bus.in_valid) begin
                        len_q[7:0] <= bus.in_data;
                        state      <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (bus.in_valid) begin
                        len_q <= len_rx;
                        if (len_rx == '0) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                            state      <= S_CHK;
`else
                            state      <= S_DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
`endif
                        end else if (len_rx > DEPTH_LEN) begin
                            state <= S_ERROR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.in_valid) begin
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
                        chk_q    <= chk_q ^ bus.in_data;
`endif
                        // New bytes enter at the top so the first byte ends up in [7:0].
                        if (byte_idx == 2'd3) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= words_loaded[ADDR_W-1:0];
                            wr_data_q <= {bus.in_data, word_buf};
                            state     <= S_WRITE;
                        end else begin
                            word_buf  <= {bus.in_data, word_buf[23:8]};
                        end
                    end
                end
                S_WRITE: begin
                    words_loaded <= cnt_next;
                    if (last_word) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                        state      <= S_CHK;
`else
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        core_rst_n <= 1'b1;
`endif
                    end else begin
                        state <= S_DATA;
                    end
                end
`ifdef IMEM_LOADER_CHKSUM_EN
                S_CHK: begin
                    if (bus.in_valid) begin
                        busy <= 1'b0;
                        if (bus.in_data == chk_q) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state <= S_ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: image loads, stalls, length limits, mid-session reset, optional checksum.
module tb_imem_loader;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;
`ifdef IMEM_LOADER_CHKSUM_EN
    localparam int CHK_EXTRA = 1;
`else
    localparam int CHK_EXTRA = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            core_rst_n, busy, done, err;
    logic [ADDR_W:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bus          (bus),
        .core_rst_n   (core_rst_n),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int wr_cnt  = 0;
    int acc_cnt = 0;
    logic [ADDR_W-1:0] log_addr [256];
    logic [31:0]       log_data [256];
    logic [7:0]        img [$];

    // Write-strobe logger and transfer counter, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            if (wr_cnt < 256) begin
                log_addr[wr_cnt] <= bus.wr_addr;
                log_data[wr_cnt] <= bus.wr_data;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.in_valid && bus.in_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rdy_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_raw(input int gap);
        foreach (img[i]) send_byte(img[i], gap);
    endtask

    task automatic send_image(input int gap);
        logic [7:0] x = 8'h00;
        foreach (img[i]) if (i >= 2) x ^= img[i];
        send_raw(gap);
`ifdef IMEM_LOADER_CHKSUM_EN
        send_byte(x, gap);
`endif
        if (x === 8'hxx) $display("checksum undefined");
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || err) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("end_timeout", 32'(done | err), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"},   32'(bus.in_ready), 32'd0);
        chk({tag, "_wr_en"},      32'(bus.wr_en), 32'd0);
        chk({tag, "_wr_addr"},    32'(bus.wr_addr), 32'd0);
        chk({tag, "_wr_data"},    bus.wr_data, 32'd0);
        chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
        chk({tag, "_busy"},       32'(busy), 32'd0);
        chk({tag, "_done"},       32'(done), 32'd0);
        chk({tag, "_err"},        32'(err), 32'd0);
        chk({tag, "_words"},      32'(words_loaded), 32'd0);
    endtask

    task automatic check_two_words(input string tag, input int base, input int acc0);
        chk({tag, "_wr_cnt"}, 32'(wr_cnt - base), 32'd2);
        chk({tag, "_addr0"},  32'(log_addr[base]), 32'd0);
        chk({tag, "_data0"},  log_data[base], 32'h0000_0013);
        chk({tag, "_addr1"},  32'(log_addr[base+1]), 32'd1);
        chk({tag, "_data1"},  log_data[base+1], 32'h0010_0093);
        chk({tag, "_acc"},    32'(acc_cnt - acc0), 32'(10 + CHK_EXTRA));
        chk({tag, "_done"},   32'(done), 32'd1);
        chk({tag, "_err"},    32'(err), 32'd0);
        chk({tag, "_corerst"},32'(core_rst_n), 32'd1);
        chk({tag, "_words"},  32'(words_loaded), 32'd2);
        chk({tag, "_busy"},   32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        int acc0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        // Reset and idle: bytes offered in IDLE must be ignored.
        #12 check_reset("rst");
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1 bus.in_data = 8'hAA;
        bus.in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("idle_acc", 32'(acc_cnt), 32'd0);
        chk("idle_wr",  32'(wr_cnt), 32'd0);
        chk("idle_busy",32'(busy), 32'd0);

        // Two-word image at full rate.
        pulse_start();
        @(negedge clk);
        chk("s1_busy",    32'(busy), 32'd1);
        chk("s1_corerst", 32'(core_rst_n), 32'd0);
        chk("s1_ready",   32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        img = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        base = wr_cnt;
        acc0 = acc_cnt;
        send_image(0);
        wait_end();
        check_two_words("full", base, acc0);

        // DONE must refuse bytes.
        acc0 = acc_cnt;
        bus.in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("done_acc", 32'(acc_cnt - acc0), 32'd0);

        // Same image with in_valid toggling.
        pulse_start();
        @(negedge clk);
        chk("s2_corerst", 32'(core_rst_n), 32'd0);
        chk("s2_done",    32'(done), 32'd0);
        @(posedge clk);
        #1;
        base = wr_cnt;
        acc0 = acc_cnt;
        send_image(1);
        wait_end();
        check_two_words("gap", base, acc0);

        // Length 65 exceeds DEPTH: abort with no writes.
        pulse_start();
        img = {8'h41, 8'h00};
        base = wr_cnt;
        send_raw(0);
        wait_end();
        chk("len65_err",     32'(err), 32'd1);
        chk("len65_done",    32'(done), 32'd0);
        chk("len65_wr",      32'(wr_cnt - base), 32'd0);
        chk("len65_corerst", 32'(core_rst_n), 32'd0);
        chk("len65_busy",    32'(busy), 32'd0);

        // Recovery from error with a one-word image.
        pulse_start();
        img = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        base = wr_cnt;
        send_image(0);
        wait_end();
        chk("rec_done",  32'(done), 32'd1);
        chk("rec_err",   32'(err), 32'd0);
        chk("rec_wr",    32'(wr_cnt - base), 32'd1);
        chk("rec_data",  log_data[base], 32'h0000_0013);
        chk("rec_words", 32'(words_loaded), 32'd1);

        // Zero-length image completes without writes.
        pulse_start();
        img = {8'h00, 8'h00};
        base = wr_cnt;
        send_image(0);
        wait_end();
        chk("len0_done",  32'(done), 32'd1);
        chk("len0_wr",    32'(wr_cnt - base), 32'd0);
        chk("len0_words", 32'(words_loaded), 32'd0);
        chk("len0_corerst", 32'(core_rst_n), 32'd1);

        // Full-depth image: 64 words, word i = {~i, 5A, A5, i}.
        pulse_start();
        img = {8'h40, 8'h00};
        for (int i = 0; i < 64; i++) begin
            img.push_back(8'(i));
            img.push_back(8'hA5);
            img.push_back(8'h5A);
            img.push_back(~8'(i));
        end
        base = wr_cnt;
        send_image(0);
        wait_end();
        chk("len64_done",  32'(done), 32'd1);
        chk("len64_wr",    32'(wr_cnt - base), 32'd64);
        chk("len64_words", 32'(words_loaded), 32'd64);
        for (int i = 0; i < 64; i++) begin
            chk("len64_addr", 32'(log_addr[base+i]), 32'(i));
            chk("len64_data", log_data[base+i], {~8'(i), 8'h5A, 8'hA5, 8'(i)});
        end

        // Reset in the middle of the first word.
        pulse_start();
        img = {8'h01, 8'h00};
        send_raw(0);
        send_byte(8'h37, 0);
        send_byte(8'h12, 0);
        #2 rst_n = 1'b0;
        #1 check_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        img = {8'h01, 8'h00, 8'h37, 8'h12, 8'h00, 8'h00};
        base = wr_cnt;
        send_image(0);
        wait_end();
        chk("post_done", 32'(done), 32'd1);
        chk("post_wr",   32'(wr_cnt - base), 32'd1);
        chk("post_addr", 32'(log_addr[base]), 32'd0);
        chk("post_data", log_data[base], 32'h0000_1237);

`ifdef IMEM_LOADER_CHKSUM_EN
        // Wrong checksum byte aborts after the write.
        pulse_start();
        img = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        base = wr_cnt;
        send_raw(0);
        send_byte(8'h12, 0);
        wait_end();
        chk("badsum_err",     32'(err), 32'd1);
        chk("badsum_done",    32'(done), 32'd0);
        chk("badsum_corerst", 32'(core_rst_n), 32'd0);
        chk("badsum_wr",      32'(wr_cnt - base), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
